// File: rtl/ksa_wb_pkg.sv
// ksa_wb_pkg: register offsets, control/status bit indices and sequencer states for ksa_wb_operand_stage
package ksa_wb_pkg;
    localparam logic [7:0] OFS_OPA    = 8'h00;
    localparam logic [7:0] OFS_OPB    = 8'h04;
    localparam logic [7:0] OFS_CTRL   = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;
    localparam logic [7:0] OFS_RESULT = 8'h10;
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ACC    = 2;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ksa_wb_seq.sv
// ksa_wb_seq: start/settle/capture sequencer; capture pulses SETTLE_CYC cycles after start
module ksa_wb_seq
    import ksa_wb_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic busy,
    output logic done,
    output logic capture
);
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // START outranks a simultaneous DONE clear
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (start && state != ST_RUN) begin
            state_n = ST_RUN;
            cnt_n   = CNT_INIT;
        end else if (state == ST_RUN) begin
            state_n = (cnt == 4'd0) ? ST_DONE : ST_RUN;
            cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
        end else if (state == ST_DONE && clear) begin
            state_n = ST_IDLE;
        end
    end
    assign busy    = state == ST_RUN;
    assign done    = state == ST_DONE;
    assign capture = busy && cnt == 4'd0;
endmodule

// File: rtl/ksa_wb_operand_stage.sv
// ksa_wb_operand_stage: Wishbone operand/result register front end for the Kogge-Stone adder.
// Optional KSA_ACC_EN adds CTRL.ACC, which folds each captured sum back into OPA.
module ksa_wb_operand_stage
    import ksa_wb_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          SETTLE_CYC = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    input  logic [WIDTH-1:0] add_sum_i,
    input  logic             add_cout_i,
    output logic             irq_o
);
    logic [7:0]       ofs;
    logic             req, wr, start, clear, busy, done, capture, irq_en, acc;
    logic [WIDTH:0]   result;
    logic [WIDTH-1:0] wmask, opa_wr, opb_wr;
    logic [31:0]      ctrl_rd, stat_rd, rd_data;
    logic             unused_bits;
    assign ofs   = wbs_adr_i[7:0];
    assign req   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr    = req & wbs_we_i;
    assign start = wr && ofs == OFS_CTRL && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
    assign clear = wr && ofs == OFS_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];
    assign unused_bits = &{1'b0, wbs_dat_i, wbs_sel_i};
    always_comb begin
        for (int i = 0; i < WIDTH; i++) wmask[i] = wbs_sel_i[i/8];
    end
    assign opa_wr = (add_a_o & ~wmask) | (wbs_dat_i[WIDTH-1:0] & wmask);
    assign opb_wr = (add_b_o & ~wmask) | (wbs_dat_i[WIDTH-1:0] & wmask);
    ksa_wb_seq #(.SETTLE_CYC(SETTLE_CYC)) u_seq (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .start   (start),
        .clear   (clear),
        .busy    (busy),
        .done    (done),
        .capture (capture)
    );
`ifdef KSA_ACC_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) acc <= 1'b0;
        else if (wr && ofs == OFS_CTRL && wbs_sel_i[0]) acc <= wbs_dat_i[CTRL_ACC];
    end
`else
    assign acc = 1'b0;
`endif
    always_comb begin
        ctrl_rd = '0;
        stat_rd = '0;
        ctrl_rd[CTRL_IRQ_EN] = irq_en;
        ctrl_rd[CTRL_ACC]    = acc;
        stat_rd[STAT_BUSY]   = busy;
        stat_rd[STAT_DONE]   = done;
        rd_data = ofs == OFS_OPA    ? 32'(add_a_o) :
                  ofs == OFS_OPB    ? 32'(add_b_o) :
                  ofs == OFS_CTRL   ? ctrl_rd :
                  ofs == OFS_STATUS ? stat_rd :
                  ofs == OFS_RESULT ? 32'(result) : '0;
    end
    // Operands stay frozen while the adder settles
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            add_a_o   <= '0;
            add_b_o   <= '0;
            result    <= '0;
            irq_en    <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;
            if (wr && ofs == OFS_OPA && !busy) add_a_o <= opa_wr;
            else if (capture && acc) add_a_o <= add_sum_i;
            if (wr && ofs == OFS_OPB && !busy) add_b_o <= opb_wr;
            if (wr && ofs == OFS_CTRL && wbs_sel_i[0]) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            if (capture) result <= {add_cout_i, add_sum_i};
        end
    end
    assign irq_o = done & irq_en;
endmodule

// File: tb/tb_ksa_wb_operand_stage.sv
// tb_ksa_wb_operand_stage: vector table, directed corner sequences and randomized model checks
module tb_ksa_wb_operand_stage;
    localparam int W = 16;
    localparam int SC = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0;
    logic [3:0] sel = 0;
    logic [31:0] dat_i = 0, adr = 0;
    logic ack, cout, irq;
    logic [31:0] dat_o;
    logic [W-1:0] a_o, b_o, sum;
    int checks = 0, errors = 0;
    typedef struct {
        logic [15:0] a0, aw;
        logic [3:0]  s;
        logic [15:0] b, ea;
        logic [16:0] er;
    } vec_t;
    vec_t vecs[7];
    assign {cout, sum} = {1'b0, a_o} + {1'b0, b_o};
    always #5 clk = ~clk;
    ksa_wb_operand_stage dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .add_a_o(a_o), .add_b_o(b_o), .add_sum_i(sum), .add_cout_i(cout), .irq_o(irq)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic ok);
        stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
        ok = 0; rd = 0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(posedge clk); #1;
            if (ack) begin ok = 1; rd = dat_o; end
        end
        stb = 0; cyc = 0; we = 0;
    endtask
    task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; logic ok;
        xfer(1, BASE + 32'(o), d, s, rd, ok);
        chk($sformatf("wr_ack@%h", o), 32'(ok), 1);
    endtask
    task automatic rd(input logic [7:0] o, output logic [31:0] d);
        logic ok;
        xfer(0, BASE + 32'(o), 0, 4'hF, d, ok);
        chk($sformatf("rd_ack@%h", o), 32'(ok), 1);
    endtask
    task automatic rdchk(input string name, input logic [7:0] o, input logic [31:0] exp);
        logic [31:0] d;
        rd(o, d);
        chk(name, d, exp);
    endtask
    task automatic wait_done();
        logic [31:0] s; logic hit;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            rd(8'h0C, s);
            hit = s[1];
        end
        chk("done_wait", 32'(hit), 1);
    endtask
    initial begin
        logic [31:0] d; logic ok; logic [3:0] acks; int cnt;
        logic [15:0] ma, mb, aw; logic [3:0] s;
        vecs[0] = '{16'h1234, 16'h1234, 4'hF, 16'h4321, 16'h1234, 17'h05555};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 4'hF, 16'h0001, 16'hFFFF, 17'h10000};
        vecs[2] = '{16'h1234, 16'h00EE, 4'h1, 16'h0000, 16'h12EE, 17'h012EE};
        vecs[3] = '{16'h1234, 16'hAB00, 4'h2, 16'h0100, 16'hAB34, 17'h0AC34};
        vecs[4] = '{16'h8000, 16'h8000, 4'hF, 16'h8000, 16'h8000, 17'h10000};
        vecs[5] = '{16'hFFFF, 16'h0000, 4'h0, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 4'h3, 16'h0F0F, 16'hF0F0, 17'h0FFFF};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_a", 32'(a_o), 0);
        chk("rst_b", 32'(b_o), 0);
        chk("rst_irq", 32'(irq), 0);
        rst = 0;
        rdchk("rst_status", 8'h0C, 0);
        rdchk("rst_result", 8'h10, 0);
        rdchk("rst_ctrl", 8'h08, 0);
        // basic add with busy observed right after start
        wr(8'h00, 32'h1234, 4'hF);
        wr(8'h04, 32'h4321, 4'hF);
        wr(8'h08, 32'h1, 4'hF);
        rdchk("busy_after_start", 8'h0C, 32'h1);
        wait_done();
        rdchk("result_5555", 8'h10, 32'h05555);
        chk("a_o_1234", 32'(a_o), 32'h1234);
        // carry out, settle timing via irq, W1C
        wr(8'h00, 32'hFFFF, 4'hF);
        wr(8'h04, 32'h0001, 4'hF);
        wr(8'h08, 32'h3, 4'hF);
        cnt = 0;
        while (!irq && cnt < 10) begin @(posedge clk); #1; cnt++; end
        chk("settle_cycles", 32'(cnt), SC);
        rdchk("result_carry", 8'h10, 32'h10000);
        chk("irq_high", 32'(irq), 1);
        wr(8'h0C, 32'h2, 4'hF);
        chk("irq_cleared", 32'(irq), 0);
        rdchk("idle_after_w1c", 8'h0C, 0);
        // START while running is ignored
        wr(8'h00, 32'h1234, 4'hF);
        wr(8'h04, 32'h1111, 4'hF);
        wr(8'h08, 32'h3, 4'hF);
        wr(8'h08, 32'h3, 4'hF);
        chk("start_in_run_ignored", 32'(irq), 1);
        rdchk("result_2345", 8'h10, 32'h02345);
        // OPA write while running is ignored
        wr(8'h0C, 32'h2, 4'hF);
        wr(8'h08, 32'h3, 4'hF);
        wr(8'h00, 32'hAAAA, 4'hF);
        wait_done();
        rdchk("opa_frozen", 8'h00, 32'h1234);
        rdchk("result_frozen_ops", 8'h10, 32'h02345);
        // byte enables, unmapped offset, outside page
        wr(8'h00, 32'h00EE, 4'h1);
        rdchk("opa_byte0", 8'h00, 32'h12EE);
        rdchk("unmapped_read", 8'h20, 0);
        xfer(0, BASE + 32'h100, 0, 4'hF, d, ok);
        chk("out_of_page_noack", 32'(ok), 0);
        // held strobe: acks never back to back
        stb = 1; cyc = 1; we = 0; adr = BASE;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; acks[i] = ack; end
        stb = 0; cyc = 0;
        chk("ack_pattern", 32'(acks), 32'h5);
        // reset mid-run
        wr(8'h08, 32'h3, 4'hF);
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_ack", 32'(ack), 0);
        chk("midrst_dat", dat_o, 0);
        chk("midrst_a", 32'(a_o), 0);
        chk("midrst_b", 32'(b_o), 0);
        chk("midrst_irq", 32'(irq), 0);
        rst = 0;
        rdchk("midrst_status", 8'h0C, 0);
        rdchk("midrst_result", 8'h10, 0);
        wr(8'h00, 32'h5, 4'hF);
        wr(8'h04, 32'h7, 4'hF);
        wr(8'h08, 32'h1, 4'hF);
        wait_done();
        rdchk("post_rst_result", 8'h10, 32'h0000C);
        // reset during an outstanding request
        stb = 1; cyc = 1; we = 0; adr = BASE; rst = 1;
        @(posedge clk); #1;
        chk("rst_req_noack", 32'(ack), 0);
        stb = 0; cyc = 0; rst = 0;
        // ACC bit
        wr(8'h08, 32'h6, 4'hF);
`ifdef KSA_ACC_EN
        rdchk("ctrl_acc", 8'h08, 32'h6);
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h04, 32'h3, 4'hF);
        for (int i = 0; i < 3; i++) begin wr(8'h08, 32'h5, 4'hF); wait_done(); end
        rdchk("acc_opa", 8'h00, 32'h9);
        rdchk("acc_result", 8'h10, 32'h00009);
`else
        rdchk("ctrl_no_acc", 8'h08, 32'h2);
`endif
        wr(8'h08, 32'h0, 4'hF);
        foreach (vecs[i]) begin
            wr(8'h00, 32'(vecs[i].a0), 4'hF);
            wr(8'h00, 32'(vecs[i].aw), vecs[i].s);
            wr(8'h04, 32'(vecs[i].b), 4'hF);
            wr(8'h08, 32'h1, 4'hF);
            wait_done();
            rdchk($sformatf("vec%0d_result", i), 8'h10, 32'(vecs[i].er));
            rdchk($sformatf("vec%0d_opa", i), 8'h00, 32'(vecs[i].ea));
        end
        for (int i = 0; i < 30; i++) begin
            ma = 16'($urandom); aw = 16'($urandom); mb = 16'($urandom); s = 4'($urandom);
            wr(8'h00, 32'(ma), 4'hF);
            wr(8'h00, 32'(aw), s);
            wr(8'h04, 32'(mb), 4'hF);
            ma = {s[1] ? aw[15:8] : ma[15:8], s[0] ? aw[7:0] : ma[7:0]};
            wr(8'h08, 32'h1, 4'hF);
            wait_done();
            rdchk($sformatf("rand%0d_result", i), 8'h10, 32'(ma) + 32'(mb));
            rdchk($sformatf("rand%0d_opa", i), 8'h00, 32'(ma));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
